// File: rtl/vend_pkg.sv
// vend_pkg: coin values, drink codes/prices and change dispenser state encoding shared across the vending slice
package vend_pkg;
  localparam logic [31:0] COIN_10 = 32'd10;
  localparam logic [31:0] COIN_5  = 32'd5;
  localparam logic [31:0] COIN_1  = 32'd1;
  typedef enum logic [2:0] {
    NO_CHOOSE = 3'd0,
    TEA       = 3'd1,
    COKE      = 3'd2,
    COFFEE    = 3'd3,
    MILK      = 3'd4
  } drink_t;
  localparam logic [31:0] PRICE_TEA    = 32'd10;
  localparam logic [31:0] PRICE_COKE   = 32'd15;
  localparam logic [31:0] PRICE_COFFEE = 32'd20;
  localparam logic [31:0] PRICE_MILK   = 32'd25;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2
  } state_t;
endpackage

// File: rtl/change_dispenser_denom_select.sv
// denom_select: greedy pick of the largest in-stock coin not exceeding the remaining amount
module denom_select
  import vend_pkg::*;
(
  input  logic [31:0] remaining,
  input  logic        stock10_nz,
  input  logic        stock5_nz,
  output logic [31:0] coin
);
  always_comb
    coin = (remaining >= COIN_10 && stock10_nz) ? COIN_10 :
           (remaining >= COIN_5 && stock5_nz)   ? COIN_5  :
           (remaining != '0)                    ? COIN_1  : '0;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a change amount back as a valid/ready stream of 10/5/1 coins
// Optional tube stock tracking for 10s and 5s is enabled by defining COIN_STOCK_EN.
module change_dispenser
  import vend_pkg::*;
#(
  parameter logic [7:0] STOCK10_INIT = 8'd8,
  parameter logic [7:0] STOCK5_INIT  = 8'd8
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] change_in,
  input  logic        change_valid,
  output logic        busy,
  output logic [31:0] coin_out,
  output logic        coin_valid,
  input  logic        coin_ready,
  output logic        done,
  output logic [7:0]  stock10,
  output logic [7:0]  stock5
);
  state_t      r_state;
  logic [31:0] r_remaining;
  logic [31:0] w_coin;
  logic        w_s10_nz;
  logic        w_s5_nz;

  denom_select u_sel (
    .remaining (r_remaining),
    .stock10_nz(w_s10_nz),
    .stock5_nz (w_s5_nz),
    .coin      (w_coin)
  );

  assign busy       = r_state != S_IDLE;
  assign coin_valid = r_state == S_DISPENSE;
  assign coin_out   = coin_valid ? w_coin : '0;
  assign done       = r_state == S_DONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (change_valid) begin
            r_remaining <= change_in;
            r_state     <= (change_in != '0) ? S_DISPENSE : S_DONE;
          end
        S_DISPENSE:
          if (coin_ready) begin
            r_remaining <= r_remaining - w_coin;
            r_state     <= (r_remaining == w_coin) ? S_DONE : S_DISPENSE;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef COIN_STOCK_EN
  logic [7:0] r_stock10;
  logic [7:0] r_stock5;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stock10 <= STOCK10_INIT;
      r_stock5  <= STOCK5_INIT;
    end else if (coin_valid && coin_ready) begin
      if (w_coin == COIN_10 && r_stock10 != '0) r_stock10 <= r_stock10 - 8'd1;
      if (w_coin == COIN_5 && r_stock5 != '0) r_stock5 <= r_stock5 - 8'd1;
    end
  end
  assign w_s10_nz = r_stock10 != '0;
  assign w_s5_nz  = r_stock5 != '0;
  assign stock10  = r_stock10;
  assign stock5   = r_stock5;
`else
  logic w_unused;
  assign w_unused = ^{STOCK10_INIT, STOCK5_INIT};
  assign w_s10_nz = 1'b1;
  assign w_s5_nz  = 1'b1;
  assign stock10  = '0;
  assign stock5   = '0;
`endif
endmodule
